// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared constants and helpers for the effects chain
package fx_pkg;

  localparam logic WAVE_TRIANGLE = 1'b0;
  localparam logic WAVE_SQUARE   = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } lfo_dir_e;

  // Unity gain for a fraction of amp_width bits.
  function automatic int unsigned amp_one(input int unsigned amp_width);
    return 32'd1 << amp_width;
  endfunction

endpackage

// File: rtl/tremolo_lfo.sv
// rtl/tremolo_lfo.sv - frame-rate triangle/square LFO with rate prescaler
module tremolo_lfo
  import fx_pkg::*;
#(
  parameter int AMP_WIDTH  = 10,
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  step_en,
  input  logic                  waveform,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [AMP_WIDTH-1:0]  lfo
);

  localparam logic [AMP_WIDTH-1:0] PHASE_MAX = '1;
  localparam logic [AMP_WIDTH-1:0] PHASE_TOP = PHASE_MAX - 1'b1;

  logic [RATE_WIDTH-1:0] presc_q, presc_d;
  logic [AMP_WIDTH-1:0]  phase_q, phase_d;
  lfo_dir_e              dir_q, dir_d;

  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    if (clr) begin
      presc_d = '0;
      phase_d = '0;
      dir_d   = DIR_UP;
    end else if (step_en) begin
      if (presc_q == rate) begin
        presc_d = '0;
        if (dir_q == DIR_UP) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == PHASE_TOP) dir_d = DIR_DOWN;
        end else begin
          phase_d = phase_q - 1'b1;
          if (phase_q == {{(AMP_WIDTH-1){1'b0}}, 1'b1}) dir_d = DIR_UP;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      phase_q <= '0;
      dir_q   <= DIR_UP;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
    end
  end

  // Square wave rides the triangle's direction bit, so both share one period.
  assign lfo = (waveform == WAVE_TRIANGLE) ? phase_q
             : ((dir_q == DIR_DOWN) ? PHASE_MAX : '0);

endmodule

// File: rtl/stereo_tremolo.sv
// rtl/stereo_tremolo.sv - multi-channel tremolo, two-stage valid/ready pipeline
module stereo_tremolo
  import fx_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 2,
  parameter int AMP_WIDTH  = 10,
  parameter int RATE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic                           waveform,
  input  logic [RATE_WIDTH-1:0]          rate,
  input  logic [AMP_WIDTH-1:0]           depth,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data
);

  localparam int FW = CHANNELS * DATA_WIDTH;
  localparam int MW = 2 * AMP_WIDTH;
  localparam int PW = DATA_WIDTH + AMP_WIDTH + 1;
  localparam int unsigned ONE_INT = amp_one(AMP_WIDTH);
  localparam logic [AMP_WIDTH:0] GAIN_UNITY = ONE_INT[AMP_WIDTH:0];

  logic                 advance, accept;
  logic [AMP_WIDTH-1:0] lfo, mod;
  logic [MW-1:0]        mod_full;
  logic [AMP_WIDTH:0]   gain;
  logic [FW-1:0]        s2_data;

  logic                 s1_valid_q, s1_valid_d;
  logic [FW-1:0]        s1_data_q, s1_data_d;
  logic [AMP_WIDTH:0]   s1_gain_q, s1_gain_d;
  logic                 out_valid_q, out_valid_d;
  logic [FW-1:0]        out_data_q, out_data_d;

  assign advance  = !out_valid_q || out_ready;
  assign accept   = in_valid && advance;
  assign in_ready = advance;

  tremolo_lfo #(
    .AMP_WIDTH (AMP_WIDTH),
    .RATE_WIDTH(RATE_WIDTH)
  ) u_lfo (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (accept && !enable),
    .step_en (accept),
    .waveform(waveform),
    .rate    (rate),
    .lfo     (lfo)
  );

  // Gain uses the LFO value before this frame's step.
  assign mod_full = MW'(depth) * MW'(lfo);
  assign mod      = AMP_WIDTH'(mod_full >> AMP_WIDTH);
  assign gain     = enable ? (GAIN_UNITY - {1'b0, mod}) : GAIN_UNITY;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [PW-1:0]         prod;
    assign sample = s1_data_q[ch*DATA_WIDTH +: DATA_WIDTH];
    assign prod   = PW'(sample) * PW'($signed({1'b0, s1_gain_q}));
    assign s2_data[ch*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(prod >>> AMP_WIDTH);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_gain_d   = s1_gain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q;
      if (accept) begin
        s1_data_d = in_data;
        s1_gain_d = gain;
      end
      if (s1_valid_q) out_data_d = s2_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_gain_q   <= GAIN_UNITY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_gain_q   <= s1_gain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
